// File: rtl/bank_arb_pkg.sv
// Shared definitions for the bank arbiter: default parameters and lock FSM state encoding.
// The lock feature is enabled by defining BANK_ARB_LOCK_EN.
package bank_arb_pkg;

    localparam int unsigned DefNumReq  = 4;
    localparam int unsigned DefAddrW   = 4;
    localparam int unsigned DefDataW   = 16;
    localparam int unsigned DefLockMax = 8;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } arb_state_e;

    // Pointer width for a given requester count; at least one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_arbiter_rr_pick.sv
// Combinational rotate-priority picker: grants the first set request at or after ptr,
// wrapping modulo N. Output is one-hot or zero.
module rr_pick
    import bank_arb_pkg::*;
#(
    parameter int unsigned N = DefNumReq
) (
    input  logic [N-1:0]            req,
    input  logic [ptr_width(N)-1:0] ptr,
    output logic [N-1:0]            grant
);

    localparam int unsigned PtrW = ptr_width(N);

    logic            found;
    logic [PtrW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PtrW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bank_arbiter.sv
// Round-robin arbiter for a single shared memory bank with optional ownership locking.
// Define BANK_ARB_LOCK_EN to build the lock FSM; otherwise req_lock is ignored.
module bank_arbiter
    import bank_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned LOCK_MAX = DefLockMax
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      bank_en,
    output logic                      bank_we,
    output logic [ADDR_W-1:0]         bank_addr,
    output logic [DATA_W-1:0]         bank_wdata,
    input  logic [DATA_W-1:0]         bank_rdata
);

    localparam int unsigned PtrW = ptr_width(NUM_REQ);

    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] pick;
    logic [NUM_REQ-1:0] grant;
    logic [PtrW-1:0]    gnt_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] rsp_valid_q;

`ifdef BANK_ARB_LOCK_EN
    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

    arb_state_e      state_q;
    logic [PtrW-1:0] owner_q;
    logic [CntW-1:0] lock_cnt_q;

    // While locked, everyone except the owner is masked out of arbitration.
    always_comb begin
        eligible = req_valid;
        if (state_q == StLocked) begin
            eligible = req_valid & (NUM_REQ'(1) << owner_q);
        end
    end

    // lock_cnt counts grants issued under the current lock, including the entry grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_any && req_lock[gnt_idx] && LOCK_MAX > 1) begin
                        state_q    <= StLocked;
                        owner_q    <= gnt_idx;
                        lock_cnt_q <= CntW'(1);
                    end
                end
                StLocked: begin
                    if (!gnt_any) begin
                        state_q    <= StIdle;
                        lock_cnt_q <= '0;
                    end else if (req_lock[owner_q] && lock_cnt_q < CntW'(LOCK_MAX - 1)) begin
                        lock_cnt_q <= lock_cnt_q + CntW'(1);
                    end else begin
                        state_q    <= StIdle;
                        lock_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    lock_cnt_q <= '0;
                end
            endcase
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign eligible    = req_valid;
`endif

    rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .req  (eligible),
        .ptr  (ptr_q),
        .grant(pick)
    );

    assign grant     = rst ? '0 : pick;
    assign gnt_any   = |grant;
    assign req_grant = grant;
    assign bank_en   = gnt_any;

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = PtrW'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + PtrW'(1);
        end
    end

    always_comb begin
        bank_we    = 1'b0;
        bank_addr  = '0;
        bank_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                bank_we    = req_we[i];
                bank_addr  = req_addr[i*ADDR_W +: ADDR_W];
                bank_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= grant & ~req_we;
        end
    end

    // Bank read data arrives the cycle after the grant, so it is forwarded unregistered.
    assign rsp_valid = rst ? '0 : rsp_valid_q;
    assign rsp_rdata = (|rsp_valid) ? bank_rdata : '0;

endmodule

// File: doc/bank_arbiter.md
BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter ADDR_W, default 4: shared bank address width.
REQ-003 Parameter DATA_W, default 16: shared bank data width.
REQ-004 Parameter LOCK_MAX, default 8: maximum consecutive grants to one locked owner.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  per-requester access request.
REQ-008 req_we  in  NUM_REQ  per-requester write (1) / read (0).
REQ-009 req_lock  in  NUM_REQ  per-requester request to keep ownership after this grant.
REQ-010 req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
REQ-011 req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
REQ-012 req_grant  out  NUM_REQ  one-hot-or-zero grant; grant = access accepted this cycle.
REQ-013 rsp_valid  out  NUM_REQ  read data valid for requester i.
REQ-014 rsp_rdata  out  DATA_W  read data, shared by all requesters.
REQ-015 bank_en, bank_we  out  1 each  bank access strobe and write select.
REQ-016 bank_addr, bank_wdata  out  ADDR_W, DATA_W  muxed from granted requester.
REQ-017 bank_rdata  in  DATA_W  bank read data, valid the cycle after bank_en with bank_we=0.

Function
REQ-018 Grant is combinational from req_valid, pointer, and lock state; at most one req_grant bit per cycle.
REQ-019 bank_en = |req_grant; bank_we/addr/wdata = granted requester's fields; all zero when no grant.
REQ-020 State IDLE: grant first requester with req_valid=1, scanning ptr, ptr+1, ... modulo NUM_REQ.
REQ-021 On any grant to index g, ptr <= (g+1) mod NUM_REQ.
REQ-022 IDLE to LOCKED when granted requester has req_lock=1: owner <= g, lock_cnt <= 1.
REQ-023 LOCKED: only owner is grantable; all other requests are held off, without grant.
REQ-024 LOCKED, owner granted with req_lock=1 and lock_cnt<LOCK_MAX: stay; lock_cnt increments.
REQ-025 LOCKED, owner granted with req_lock=0, or lock_cnt==LOCK_MAX: grant issued, then to IDLE; lock_cnt <= 0.
REQ-026 LOCKED, owner req_valid=0: no grant that cycle, then to IDLE.
REQ-027 A read grant to i in cycle N gives rsp_valid[i]=1 and rsp_rdata=bank_rdata in cycle N+1 only; writes produce no response.
REQ-028 Back-to-back reads give one rsp_valid pulse per grant, with no bubbles.

Reset
REQ-029 While rst=1: req_grant=0, bank_en=0, bank_we=0, bank_addr=0, bank_wdata=0, rsp_valid=0, rsp_rdata=0.
REQ-030 After reset: state=IDLE, ptr=0, lock_cnt=0, owner=0.
REQ-031 rst during LOCKED or with a read in flight: lock dropped, pending response discarded.

Configuration
REQ-032 Macro BANK_ARB_LOCK_EN defined: lock behaviour per REQ-022..REQ-026.
REQ-033 Macro BANK_ARB_LOCK_EN undefined: req_lock ignored, LOCKED state and lock_cnt not built, pure round-robin.

Structure
REQ-034 Shared package bank_arb_pkg holds the state encoding (IDLE, LOCKED) and the default parameter constants.
REQ-035 Sub-module rr_pick: combinational rotate-priority one-hot picker (req vector, ptr) -> grant vector.

Verification
REQ-036 Reset: rst=1 with all req_valid=1 -> req_grant=0, bank_en=0; after release, first grant is 4'b0001.
REQ-037 Round-robin: req_valid=4'b1111 held 8 cycles, no lock -> grants 0001,0010,0100,1000,0001,0010,0100,1000.
REQ-038 Read latency: req 2 reads addr 4'h5 with bank_rdata=16'hBEEF in cycle N+1 -> rsp_valid=4'b0100, rsp_rdata=16'hBEEF in N+1 only.
REQ-039 Lock (macro on): req 1 lock=1 for 3 grants then lock=0, req 3 pending -> grants 0010 x4, then 1000.
REQ-040 Lock cap: req 0 lock held at 1, req 2 pending -> exactly 8 grants to req 0, then grant 0100.
REQ-041 Mid-lock reset: rst asserted in LOCKED with read in flight -> rsp_valid=0 next cycle; round-robin restarts at req 0.
